// File: rtl/fp_pkg.sv
// Shared floating-point constants and the unpacked-operand view used by the
// add/sub pipeline and its bench.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

  // Canonical quiet NaN at the default widths.
  localparam logic [FP_EXP_W+FP_MAN_W:0] FP_QNAN =
    {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] mant;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [FP_EXP_W+FP_MAN_W:0] w);
    return fp_unpacked_t'(w);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports W_IN.
module fp_lzc #(
  parameter int W_IN = 27,
  parameter int CW   = $clog2(W_IN + 1)
) (
  input  logic [W_IN-1:0] din,
  output logic [CW-1:0]   cnt
);

  // Later (higher) set bits overwrite earlier ones, leaving the MSB's count.
  always_comb begin
    cnt = CW'(W_IN);
    for (int i = 0; i < W_IN; i++) begin
      if (din[i]) cnt = CW'(W_IN - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: align, add, normalise/round.
// Handshake: a beat moves on valid && ready; the whole pipe freezes while out_valid && !out_ready.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in0,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [2:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;
  localparam int LZW = $clog2(FW + 1);
  localparam logic [EXP_W-1:0]   EXP_ONES = '1;
  localparam logic [W-1:0]       QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] EXP_TOP = {2'b00, EXP_ONES};

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_word;
    logic             spec_inv;
    logic             sign;
    logic             zsign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [FW-1:0]    big;
    logic [FW-1:0]    sml;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_word;
    logic             spec_inv;
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] exp;
    logic [FW:0]      sum;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
  logic [W-1:0] out_d, out_q;
  logic [2:0]   flags_d, flags_q;
  logic en;

  assign en        = !(out_valid_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic             a_s, b_s, a_zero, b_zero, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] a_e, b_e, big_e, sml_e, diff;
  logic [MAN_W-1:0] a_m, b_m;
  logic [FW-1:0]    a_f, b_f, big_f, sml_f, sml_al;

  always_comb begin
    a_s    = in0[W-1];
    a_e    = in0[W-2:MAN_W];
    a_m    = in0[MAN_W-1:0];
    b_s    = in1[W-1] ^ op;
    b_e    = in1[W-2:MAN_W];
    b_m    = in1[MAN_W-1:0];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_nan  = (a_e == EXP_ONES) && (a_m != '0);
    b_nan  = (b_e == EXP_ONES) && (b_m != '0);
    a_snan = a_nan && !a_m[MAN_W-1];
    b_snan = b_nan && !b_m[MAN_W-1];
    a_inf  = (a_e == EXP_ONES) && (a_m == '0);
    b_inf  = (b_e == EXP_ONES) && (b_m == '0);
    // Subnormals are flushed: no hidden bit and no fraction.
    a_f    = a_zero ? '0 : {1'b1, a_m, 3'b000};
    b_f    = b_zero ? '0 : {1'b1, b_m, 3'b000};
    swap   = {b_e, b_f} > {a_e, a_f};
    big_e  = swap ? b_e : a_e;
    sml_e  = swap ? a_e : b_e;
    big_f  = swap ? b_f : a_f;
    sml_f  = swap ? a_f : b_f;
    diff   = big_e - sml_e;
    if (32'(diff) >= MAN_W + 3) begin
      sml_al = {{(FW-1){1'b0}}, |sml_f};
    end else begin
      sml_al = (sml_f >> diff) | {{(FW-1){1'b0}}, |(sml_f & ~({FW{1'b1}} << diff))};
    end

    s1_d           = '0;
    s1_d.sign      = swap ? b_s : a_s;
    s1_d.zsign     = a_s & b_s;
    s1_d.sub       = a_s ^ b_s;
    s1_d.exp       = big_e;
    s1_d.big       = big_f;
    s1_d.sml       = sml_al;
    if (a_nan || b_nan) begin
      s1_d.spec      = 1'b1;
      s1_d.spec_word = QNAN;
      s1_d.spec_inv  = a_snan || b_snan;
    end else if (a_inf && b_inf) begin
      s1_d.spec      = 1'b1;
      s1_d.spec_word = (a_s != b_s) ? QNAN : {a_s, EXP_ONES, {MAN_W{1'b0}}};
      s1_d.spec_inv  = (a_s != b_s);
    end else if (a_inf || b_inf) begin
      s1_d.spec      = 1'b1;
      s1_d.spec_word = {a_inf ? a_s : b_s, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // ---------------- S2: magnitude add / subtract ----------------
  always_comb begin
    s2_d           = '0;
    s2_d.spec      = s1_q.spec;
    s2_d.spec_word = s1_q.spec_word;
    s2_d.spec_inv  = s1_q.spec_inv;
    s2_d.sign      = s1_q.sign;
    s2_d.zsign     = s1_q.zsign;
    s2_d.exp       = s1_q.exp;
    s2_d.sum       = s1_q.sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.sml})
                              : ({1'b0, s1_q.big} + {1'b0, s1_q.sml});
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]   lz;
  logic [FW-1:0]    nm;
  logic [EXP_W+1:0] ne, re;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic             round_up;
  logic [W-1:0]     res;
  logic [2:0]       res_flags;

  fp_lzc #(.W_IN(FW), .CW(LZW)) u_lzc (
    .din (s2_q.sum[FW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    if (s2_q.sum[FW]) begin
      nm = {s2_q.sum[FW:2], s2_q.sum[1] | s2_q.sum[0]};
      ne = {2'b00, s2_q.exp} + {{(EXP_W+1){1'b0}}, 1'b1};
    end else begin
      nm = s2_q.sum[FW-1:0] << lz;
      ne = {2'b00, s2_q.exp} - {{(EXP_W+2-LZW){1'b0}}, lz};
    end
    // Round to nearest even on guard/round/sticky.
    round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
    mr       = {1'b0, nm[FW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (mr[MAN_W+1]) begin
      re   = ne + {{(EXP_W+1){1'b0}}, 1'b1};
      frac = mr[MAN_W:1];
    end else begin
      re   = ne;
      frac = mr[MAN_W-1:0];
    end

    res       = {s2_q.sign, re[EXP_W-1:0], frac};
    res_flags = 3'b000;
    if (s2_q.spec) begin
      res       = s2_q.spec_word;
      res_flags = {s2_q.spec_inv, 2'b00};
    end else if (s2_q.sum == '0) begin
      res = {s2_q.zsign, {(W-1){1'b0}}};
    end else if ($signed(re) <= 0) begin
      res       = {s2_q.sign, {(W-1){1'b0}}};
      res_flags = 3'b001;
    end else if ($signed(re) >= EXP_TOP) begin
      res       = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 3'b010;
    end
  end

  // ---------------- control and output registers ----------------
  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    if (en) begin
      v1_d        = in_valid;
      v2_d        = v1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_d   = res;
        flags_d = res_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (FP32): exact-integer reference model, scoreboard
// with latency/stall tracking, directed corner cases and randomized traffic.
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  localparam int XW = 35;  // {flags, word}

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in0 = '0, in1 = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [2:0]  flags;

  int checks = 0, errors = 0, cyc = 0, stalls = 0;
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] pend_q[$];
  int acc_q[$], stl_q[$];
  bit rnd_on = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  fp_addsub_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference model: exact integer sum then RNE ----------------
  function automatic logic [XW-1:0] model(input logic [31:0] a_w, input logic [31:0] b_w,
                                          input logic o);
    fp_unpacked_t a, b;
    logic sa, sb, s, a_nan, b_nan, a_inf, b_inf, rup;
    logic [299:0] ua, ub, m, keep, rem, half, one;
    int p, e, sh;
    a = fp_unpack(a_w);
    b = fp_unpack(b_w);
    sa = a.sign;
    sb = b.sign ^ o;
    a_nan = (a.exp == 8'hFF) && (a.mant != 0);
    b_nan = (b.exp == 8'hFF) && (b.mant != 0);
    a_inf = (a.exp == 8'hFF) && (a.mant == 0);
    b_inf = (b.exp == 8'hFF) && (b.mant == 0);
    if (a_nan || b_nan)
      return {(a_nan && !a.mant[22]) || (b_nan && !b.mant[22]), 2'b00, FP_QNAN};
    if (a_inf && b_inf)
      return (sa != sb) ? {3'b100, FP_QNAN} : {3'b000, sa, 8'hFF, 23'd0};
    if (a_inf) return {3'b000, sa, 8'hFF, 23'd0};
    if (b_inf) return {3'b000, sb, 8'hFF, 23'd0};
    // Value = integer * 2^(-149); subnormals read as zero.
    ua = '0;
    ub = '0;
    if (a.exp != 0) begin ua = {276'd0, 1'b1, a.mant}; ua = ua << (a.exp - 1); end
    if (b.exp != 0) begin ub = {276'd0, 1'b1, b.mant}; ub = ub << (b.exp - 1); end
    if (sa == sb) begin m = ua + ub; s = sa; end
    else if (ua >= ub) begin m = ua - ub; s = sa; end
    else begin m = ub - ua; s = sb; end
    if (m == 0) return {3'b000, sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    e = p - 22;
    one = 300'd1;
    if (p > 23) begin
      sh   = p - 23;
      keep = m >> sh;
      rem  = m & ((one << sh) - one);
      half = one << (sh - 1);
      rup  = (rem > half) || ((rem == half) && keep[0]);
      keep = keep + {299'd0, rup};
      if (keep[24]) begin keep = keep >> 1; e++; end
    end else begin
      keep = m << (23 - p);
    end
    if (e < 1)   return {3'b001, s, 31'd0};
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    return {3'b000, s, e[7:0], keep[22:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic          prev_stall = 1'b0;
  logic [XW-1:0] prev_res = '0;

  always @(negedge clk) begin
    logic [XW-1:0] e;
    int a, s;
    cyc++;
    if (!rstn) begin
      chk("reset_outputs", {out_valid, flags, out}, 64'd0);
      exp_q.delete();
      acc_q.delete();
      stl_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) chk("hold_stable", {out_valid, flags, out}, {1'b1, prev_res});
      if (out_valid) chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        s = stl_q.pop_front();
        chk("result", {flags, out}, e);
        chk("latency", 64'(cyc - a), 64'(3 + stalls - s));
      end
      if (out_valid && !out_ready) stalls++;
      prev_stall = out_valid && !out_ready;
      prev_res   = {flags, out};
      if (in_valid && in_ready) begin
        chk("pending_expected", 64'(pend_q.size() > 0), 64'd1);
        if (pend_q.size() > 0) begin
          exp_q.push_back(pend_q.pop_front());
          acc_q.push_back(cyc);
          stl_q.push_back(stalls);
        end
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [XW-1:0] e);
    int n;
    in0 = a;
    in1 = b;
    op = o;
    in_valid = 1'b1;
    pend_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1'b1);
      void'(pend_q.pop_back());
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_operand(input logic [31:0] ref_w);
    logic [31:0] sp[9];
    logic [7:0]  ex;
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
           32'h7F80_0001, 32'h0000_0001, 32'h7F7F_FFFF, 32'h0080_0000};
    case ($urandom_range(0, 9))
      0: return sp[$urandom_range(0, 8)];
      1, 2, 3: begin
        ex = ref_w[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
        return {1'($urandom_range(0, 1)), ex, 23'($urandom())};
      end
      4: return {~ref_w[31], ref_w[30:0]};
      5: return {1'($urandom_range(0, 1)), ref_w[30:0] ^ 31'($urandom_range(0, 3))};
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed cases ----------------
  localparam int ND = 16;
  logic [31:0] d_a[ND] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                           32'h7F80_0000, 32'h7F7F_FFFF, 32'h00C0_0000, 32'h8000_0000,
                           32'h8000_0000, 32'h0000_0000, 32'h7FC0_0001, 32'h7F80_0001,
                           32'h3F80_0000, 32'h0000_0001, 32'h4040_0000, 32'h3F80_0001};
  logic [31:0] d_b[ND] = '{32'h3F80_0000, 32'h3380_0000, 32'h3380_0001, 32'h3F80_0000,
                           32'h7F80_0000, 32'h7F7F_FFFF, 32'h0080_0000, 32'h8000_0000,
                           32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000,
                           32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
  logic        d_o[ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] d_r[ND] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h0000_0000,
                           32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,
                           32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                           32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3400_0000};
  logic [2:0]  d_f[ND] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000,
                           3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};

  // ---------------- main sequence ----------------
  initial begin
    int st0, n;
    logic [31:0] a, b;
    logic o;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Pin the model to hand-computed values, then drive the same cases.
    for (int i = 0; i < ND; i++) chk("model_pin", model(d_a[i], d_b[i], d_o[i]), {d_f[i], d_r[i]});
    for (int i = 0; i < ND; i++) send(d_a[i], d_b[i], d_o[i], {d_f[i], d_r[i]});
    idle(8);

    // Back-to-back stream of 8 with a 4-cycle downstream stall mid-stream.
    st0 = stalls;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = $urandom();
          b = gen_operand(a);
          o = 1'($urandom_range(0, 1));
          send(a, b, o, model(a, b, o));
        end
      end
      begin
        idle(5);
        out_ready = 1'b0;
        idle(4);
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("stall_cycles", 64'(stalls - st0), 64'd4);

    // Reset with two operations in flight; only the next op may emerge.
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4000_0000});
    send(32'h4000_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4040_0000});
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(6);
    send(32'h4040_0000, 32'h3F80_0000, 1'b1, {3'b000, 32'h4000_0000});
    idle(6);

    // Randomized traffic with random backpressure.
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          a = $urandom();
          b = gen_operand(a);
          if ($urandom_range(0, 7) == 0) a = gen_operand(b);
          o = 1'($urandom_range(0, 1));
          send(a, b, o, model(a, b, o));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size() + pend_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
